// File: rtl/addr_arb_mux.sv
// N-channel address multiplexer feeding one memory port: captures a requesting
// channel's address by external select or round-robin, holds it under a
// valid/ready handshake and returns a one-cycle grant to the served channel.
module addr_arb_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] in_addr,
    output logic [WIDTH-1:0]   out_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_ch,
    output logic [N-1:0]       grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_addr;
    logic             r_valid;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_rr_last;
    logic [N-1:0]     r_grant;

    logic             w_ext_hit;
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_rr_ch;
    logic             w_hit;
    logic [SEL_W-1:0] w_ch;

    // Comparing sel against each legal index means sel>=N simply never matches.
    always_comb begin
        w_ext_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k) && req[k]) begin
                w_ext_hit = 1'b1;
            end
        end
    end

    // Scan from the farthest offset down so the nearest requester after
    // rr_last wins; the index wraps modulo N, never modulo 2**SEL_W.
    always_comb begin
        logic [SEL_W:0] idx;
        w_rr_hit = 1'b0;
        w_rr_ch  = '0;
        idx      = '0;
        for (int off = N; off >= 1; off--) begin
            idx = {1'b0, r_rr_last} + (SEL_W+1)'(off);
            if (idx >= (SEL_W+1)'(N)) begin
                idx = idx - (SEL_W+1)'(N);
            end
            if (req[idx[SEL_W-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_ch  = idx[SEL_W-1:0];
            end
        end
    end

    assign w_hit = mode ? w_rr_hit : w_ext_hit;
    assign w_ch  = mode ? w_rr_ch  : sel;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hit) w_next = HOLD;
            HOLD:    if (out_ready) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr    <= '0;
            r_valid   <= 1'b0;
            r_ch      <= '0;
            r_grant   <= '0;
            r_rr_last <= SEL_W'(N - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_addr    <= in_addr[w_ch*WIDTH +: WIDTH];
                        r_ch      <= w_ch;
                        r_valid   <= 1'b1;
                        r_rr_last <= w_ch;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_grant <= N'(1) << r_ch;
                    end
                end
                ACK: begin
                    r_grant <= '0;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign out_addr  = r_addr;
    assign out_valid = r_valid;
    assign out_ch    = r_ch;
    assign grant     = r_grant;

endmodule

// File: doc/addr_arb_mux.md
Name: addr_arb_mux

Overview:
- Parametrised successor to the fixed 8:1 combinational address multiplexer that feeds the shared memory port from the learnCost … selectMyAction submodules.
- Selects one of N requesting channels and registers its address, either by external select (legacy mode) or by internal round-robin arbitration.
- Presents the address to the memory side with a valid/ready handshake and returns a one-cycle grant pulse to the served channel.

Parameters:
- WIDTH, 16, address word width in bits.
- N, 8, number of input channels (2..16).
- SEL_W, 3, select/index width; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  reset, asynchronous assert, active-low.
- mode  input  1  0 = external select, 1 = round-robin arbitration.
- sel  input  SEL_W  channel select, used only when mode=0.
- req  input  N  per-channel request, level; held until that channel's grant.
- in_addr  input  N*WIDTH  packed addresses; channel k occupies bits [k*WIDTH +: WIDTH].
- out_addr  output  WIDTH  registered selected address.
- out_valid  output  1  out_addr valid to memory side.
- out_ready  input  1  memory side accepts when out_valid & out_ready at a rising edge.
- out_ch  output  SEL_W  index of the channel currently held or just granted.
- grant  output  N  one-hot, one-cycle acknowledge to the served channel.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (async, nrst=0):
  - state=IDLE; out_addr=0; out_valid=0; out_ch=0; grant=0.
  - Round-robin pointer rr_last=N-1, so channel 0 has first priority.
- FSM states: IDLE, HOLD, ACK.
- IDLE, capture rule:
  - mode=0: eligible iff sel<N and req[sel]=1; chosen channel = sel.
  - mode=1: chosen channel = first k with req[k]=1, scanning rr_last+1, rr_last+2, … modulo N.
  - If a chosen channel exists at the edge, register it: out_addr<=in_addr[ch], out_ch<=ch, out_valid<=1, rr_last<=ch (in both modes), go to HOLD.
  - Otherwise remain in IDLE with outputs unchanged; out_valid stays 0.
- HOLD:
  - out_addr, out_ch and out_valid=1 are held stable regardless of req, sel, mode or in_addr changes.
  - On an edge with out_ready=1: out_valid<=0, grant<=one-hot(out_ch), go to ACK.
  - If out_ready=0, remain in HOLD indefinitely.
- ACK:
  - grant is high for exactly this one cycle.
  - Next edge: grant<=0, go to IDLE.
  - No capture is performed in ACK.
  - The granted channel must drop req by the edge ending ACK; if it does not, it is treated as a new request in IDLE.
- Latency and throughput:
  - req→out_valid is 1 cycle.
  - Accept edge→grant visible is 1 cycle.
  - Minimum 3 cycles per transfer; no back-to-back capture.
- Mode or sel changes while in HOLD/ACK take effect at the next IDLE evaluation only.
- sel>=N in mode 0: no capture, FSM stays in IDLE.
- Round-robin wrap: pointer arithmetic is modulo N, not modulo 2**SEL_W; indices >=N are never chosen.
- Single requester: served every 3 cycles with out_ready tied high.
- All req=0: stay in IDLE, no output change.
- Reset mid-HOLD or mid-ACK: immediate return to reset values; the in-flight address is dropped and no grant is issued.
- out_addr retains its last value after acceptance; only out_valid qualifies it.

Test Plan:
- Reset: nrst=0 with req=8'hFF, mode=1 → out_valid=0, out_addr=0, grant=0 throughout; after release, first capture is ch0.
- Legacy mode: mode=0, sel=5, req[5]=1, in_addr ch5=16'h1234, out_ready=1 → out_valid=1, out_addr=16'h1234 next cycle; grant=8'h20 for exactly one cycle after that; then IDLE.
- Round-robin fairness: mode=1, req=8'b1000_0101 held, requesters drop req on grant and re-raise it one cycle later, out_ready=1 → grant order 0,2,7,0,2,7.
- Backpressure: capture ch3, out_ready=0 for 10 cycles while in_addr ch3 and sel toggle → out_addr and out_valid stable; ready=1 yields grant=8'h08 one cycle later.
- Boundary: mode=0, N=6, sel=7 with req=6'h3F → no capture; out_valid remains 0.
- Async reset mid-HOLD: assert nrst low between clock edges while out_valid=1 → out_valid=0 immediately; no grant pulse; rr_last restored so the next capture (mode=1, req all high) is ch0.
